// File: rtl/aes_gf_pkg.sv
`default_nettype none
// ============================================================================
//  Module     : aes_gf_pkg
//  Purpose    : Shared GF(2^8) helpers for the AES MixColumns datapath:
//               the reduction polynomial, xtime, constant-coefficient
//               multiply and the controller state encoding.
//  Ports      : none (package)
//  Config     : none
//  Revision   : 1.0  initial release
// ============================================================================
package aes_gf_pkg;

  // Low byte of x^8 + x^4 + x^3 + x + 1 (0x11b); x^8 is implied by xtime.
  localparam logic [7:0] c_gf_poly = 8'h1b;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Multiply by x (02) with reduction.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? c_gf_poly : 8'h00);
  endfunction

  // Multiply by a 4-bit constant coefficient using an xtime chain.
  // Callers pass literal coefficients, so the unused partial products fold away.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return ({8{c[0]}} & a) ^ ({8{c[1]}} & x2) ^ ({8{c[2]}} & x4) ^ ({8{c[3]}} & x8);
  endfunction

endpackage : aes_gf_pkg
`default_nettype wire

// File: rtl/mix_column_lane.sv
`default_nettype none
// ============================================================================
//  Module     : mix_column_lane
//  Purpose    : Combinational MixColumns / InvMixColumns of one 32-bit column.
//               col_i[31:24] is row 0.
//  Ports      : col_i [31:0] column in
//               inv_i        1 = inverse transform (only with MIXCOL_INV_EN)
//               col_o [31:0] transformed column
//  Config     : MIXCOL_INV_EN - build the inverse datapath; when undefined,
//               inv_i is ignored and the forward transform is always applied.
//  Revision   : 1.0  initial release
// ============================================================================
module mix_column_lane
  import aes_gf_pkg::*;
(
  input  logic [31:0] col_i,
  input  logic        inv_i,
  output logic [31:0] col_o
);

  logic [7:0] w_a [4];
  logic [7:0] w_b [4];

  assign w_a[0] = col_i[31:24];
  assign w_a[1] = col_i[23:16];
  assign w_a[2] = col_i[15:8];
  assign w_a[3] = col_i[7:0];

  for (genvar r = 0; r < 4; r++) begin : g_row
    logic [7:0] w_fwd;
    assign w_fwd = gf_mul(w_a[r], 4'h2) ^ gf_mul(w_a[(r+1)%4], 4'h3)
                 ^ w_a[(r+2)%4] ^ w_a[(r+3)%4];
`ifdef MIXCOL_INV_EN
    logic [7:0] w_inv;
    assign w_inv = gf_mul(w_a[r], 4'he) ^ gf_mul(w_a[(r+1)%4], 4'hb)
                 ^ gf_mul(w_a[(r+2)%4], 4'hd) ^ gf_mul(w_a[(r+3)%4], 4'h9);
    assign w_b[r] = inv_i ? w_inv : w_fwd;
`else
    assign w_b[r] = w_fwd;
`endif
  end

`ifndef MIXCOL_INV_EN
  logic w_unused_inv;
  assign w_unused_inv = inv_i;
`endif

  assign col_o = {w_b[0], w_b[1], w_b[2], w_b[3]};

endmodule : mix_column_lane
`default_nettype wire

// File: rtl/mix_columns_pipe.sv
`default_nettype none
// ============================================================================
//  Module     : mix_columns_pipe
//  Purpose    : Iterative AES (Inv)MixColumns over a 128-bit state, LANES
//               columns per cycle, valid/ready on both sides.
//  Params     : LANES   columns per cycle (1, 2 or 4)
//               OUT_REG 1 = registered data_out, 0 = driven from working reg
//  Ports      : clk, rst_n (async, active low)
//               in_valid/in_ready/data_in[127:0]/inv   input handshake
//               out_valid/out_ready/data_out[127:0]    output handshake
//               data_in[127:96] is column 0; row 0 is the top byte of a column.
//  Config     : MIXCOL_INV_EN - enables the inverse transform (see lane).
//  Revision   : 1.0  initial release
// ============================================================================
module mix_columns_pipe
  import aes_gf_pkg::*;
#(
  parameter int LANES   = 1,
  parameter int OUT_REG = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic         inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out
);

  state_t            state_q, state_d;
  logic [1:0]        col_q, col_d;
  logic              inv_q, inv_d;
  // Element 0 is the most-significant word, i.e. column 0.
  logic [0:3][31:0]  work_q, work_d;

  logic [31:0]       w_lane_out [LANES];
  logic [2:0]        w_col_sum;
  logic              w_accept;
  logic              w_last;

  assign w_accept  = in_valid & in_ready;
  assign w_col_sum = {1'b0, col_q} + 3'(LANES);
  // Final BUSY cycle: this edge writes the last columns.
  assign w_last    = (state_q == ST_BUSY) && w_col_sum[2];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_BUSY;
      ST_BUSY: if (w_col_sum[2]) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = in_valid ? ST_BUSY : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    out_valid = (state_q == ST_DONE);
  end

  // ---------------- Column lanes ----------------
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mix_column_lane u_lane (
      .col_i (work_q[col_q + 2'(g)]),
      .inv_i (inv_q),
      .col_o (w_lane_out[g])
    );
  end

  // ---------------- Working register ----------------
  always_comb begin
    work_d = work_q;
    col_d  = col_q;
    inv_d  = inv_q;
    if (w_accept) begin
      work_d = data_in;
      col_d  = 2'd0;
      inv_d  = inv;
    end else if (state_q == ST_BUSY) begin
      col_d = w_col_sum[1:0];
      for (int g = 0; g < LANES; g++) begin
        work_d[col_q + 2'(g)] = w_lane_out[g];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q <= '0;
      col_q  <= 2'd0;
      inv_q  <= 1'b0;
    end else begin
      work_q <= work_d;
      col_q  <= col_d;
      inv_q  <= inv_d;
    end
  end

  // ---------------- Output stage ----------------
  if (OUT_REG != 0) begin : g_out_reg
    logic [127:0] data_out_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      data_out_q <= '0;
      else if (w_last) data_out_q <= work_d;
    end
    assign data_out = data_out_q;
  end else begin : g_out_comb
    // Working register is frozen outside BUSY, so DONE holds it stable.
    assign data_out = work_q;
  end

endmodule : mix_columns_pipe
`default_nettype wire

// File: tb/tb_mix_columns_pipe.sv
`default_nettype none
// ============================================================================
//  Module     : tb_mix_columns_pipe
//  Purpose    : Directed self-checking bench. Three instances share clk and
//               rst_n: idx0 LANES=1/OUT_REG=1, idx1 LANES=2/OUT_REG=0,
//               idx2 LANES=4/OUT_REG=1.
//  Config     : MIXCOL_INV_EN selects the inverse or forward-only expectation.
//  Revision   : 1.0  initial release
// ============================================================================
module tb_mix_columns_pipe;

  localparam logic [127:0] c_ref_in  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] c_ref_out = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] c_db_x4   = {4{32'hdb135345}};
  localparam logic [127:0] c_8e_x4   = {4{32'h8e4da1bc}};
  localparam logic [127:0] c_d4_x4   = {4{32'hd4d4d4d5}};
  localparam logic [127:0] c_d5_x4   = {4{32'hd5d5d7d6}};
  localparam logic [127:0] c_2d_x4   = {4{32'h2d26314c}};
  localparam logic [127:0] c_4d_x4   = {4{32'h4d7ebdf8}};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         iv    [3];
  logic         ir    [3];
  logic         inv_s [3];
  logic         ov    [3];
  logic         ordy  [3];
  logic [127:0] din   [3];
  logic [127:0] dout  [3];

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  mix_columns_pipe #(.LANES(1), .OUT_REG(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .data_in(din[0]),
    .inv(inv_s[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .data_out(dout[0]));
  mix_columns_pipe #(.LANES(2), .OUT_REG(0)) u_dut_l2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .data_in(din[1]),
    .inv(inv_s[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .data_out(dout[1]));
  mix_columns_pipe #(.LANES(4), .OUT_REG(1)) u_dut_l4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .data_in(din[2]),
    .inv(inv_s[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .data_out(dout[2]));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transaction; optionally keeps in_valid high with junk while busy.
  task automatic do_op(input int k, input logic [127:0] data, input logic inv_v,
                       input bit junk, input logic [127:0] exp, input int exp_lat,
                       input string tag);
    int waited = 0;
    int lat    = 0;
    @(negedge clk);
    while (!ir[k] && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, " ready"}, 128'(ir[k]), 128'd1);
    iv[k]    = 1'b1;
    din[k]   = data;
    inv_s[k] = inv_v;
    @(posedge clk);
    #1;
    if (junk) begin
      din[k]   = '1;
      inv_s[k] = ~inv_v;
    end else begin
      iv[k] = 1'b0;
    end
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!ov[k] && lat < 20);
    iv[k] = 1'b0;
    chk({tag, " latency"}, 128'(lat), 128'(exp_lat));
    chk({tag, " data"}, dout[k], exp);
  endtask

  initial begin
    logic [127:0] held;
    int           t_out [2];
    logic [127:0] d_out [2];
    int           nout;
    int           sent;
    bit           hs_prev;

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; inv_s[k] = 1'b0; ordy[k] = 1'b1; din[k] = '0;
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst ov%0d", k), 128'(ov[k]), 128'd0);
      chk($sformatf("rst dout%0d", k), dout[k], 128'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("post-rst ir%0d", k), 128'(ir[k]), 128'd1);

    // LANES=4 forward, reference columns, one-cycle latency.
    do_op(2, c_ref_in, 1'b0, 1'b0, c_ref_out, 1, "l4 fwd");
    do_op(2, c_d4_x4, 1'b0, 1'b0, c_d5_x4, 1, "l4 fwd d4");

    // LANES=1, inv requested; junk in_valid held during BUSY must be ignored.
`ifdef MIXCOL_INV_EN
    do_op(0, c_ref_out, 1'b1, 1'b1, c_ref_in, 4, "l1 inv");
`else
    do_op(0, c_db_x4, 1'b1, 1'b1, c_8e_x4, 4, "l1 inv-off");
`endif
    do_op(0, c_2d_x4, 1'b0, 1'b0, c_4d_x4, 4, "l1 fwd 2d");

    // LANES=2 with downstream stall.
    ordy[1] = 1'b0;
    do_op(1, c_2d_x4, 1'b0, 1'b0, c_4d_x4, 2, "l2 stall");
    held    = dout[1];
    iv[1]   = 1'b1;
    din[1]  = c_d4_x4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d data", i), dout[1], held);
      chk($sformatf("stall%0d ir", i), 128'(ir[1]), 128'd0);
      chk($sformatf("stall%0d ov", i), 128'(ov[1]), 128'd1);
    end
    iv[1]   = 1'b0;
    ordy[1] = 1'b1;
    @(posedge clk);
    #1;
    chk("stall drain ov", 128'(ov[1]), 128'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("stall no 2nd ov", 128'(ov[1]), 128'd0);
    chk("stall idle ir", 128'(ir[1]), 128'd1);

    // LANES=2 back-to-back with in_valid held high.
    nout = 0; sent = 0; hs_prev = 1'b0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      if (ov[1] && nout < 2) begin
        t_out[nout] = cyc;
        d_out[nout] = dout[1];
        nout++;
      end
      if (hs_prev) sent++;
      iv[1]   = (sent < 2);
      din[1]  = (sent == 0) ? c_d4_x4 : c_2d_x4;
      inv_s[1] = 1'b0;
      #1;
      hs_prev = iv[1] && ir[1];
    end
    iv[1] = 1'b0;
    chk("b2b count", 128'(nout), 128'd2);
    chk("b2b first", d_out[0], c_d5_x4);
    chk("b2b second", d_out[1], c_4d_x4);
    chk("b2b spacing", 128'(t_out[1] - t_out[0]), 128'd3);

    // Reset pulse during BUSY on LANES=1 (its data_out still holds a result).
    @(negedge clk);
    iv[0] = 1'b1; din[0] = c_ref_in; inv_s[0] = 1'b0;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid-rst ov", 128'(ov[0]), 128'd0);
    chk("mid-rst dout", dout[0], 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid-rst ir", 128'(ir[0]), 128'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("mid-rst no partial", 128'(ov[0]), 128'd0);
    do_op(0, c_ref_in, 1'b0, 1'b0, c_ref_out, 4, "l1 after rst");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_mix_columns_pipe
`default_nettype wire
